// File: rtl/param_sync_ram_clr.sv
// Parametrised single-port synchronous scratch RAM with registered, valid-flagged reads,
// out-of-range error pulses and a post-reset clear engine that holds BUSY until done.
module param_sync_ram_clr #(
  parameter int                DATA_W   = 8,
  parameter int                ADDR_W   = 6,
  parameter int                DEPTH    = 64,
  parameter int                RDW_MODE = 0,
  parameter logic [DATA_W-1:0] CLR_VAL  = '0
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [DATA_W-1:0] D_IN,
  input  logic [ADDR_W-1:0] ADDR,
  input  logic              R_ENABLE,
  input  logic              W_ENABLE,
  output logic [DATA_W-1:0] D_OUT,
  output logic              R_VALID,
  output logic              BUSY,
  output logic              ADDR_ERR,
  output logic              STATE_DBG
);

  // Handshake: a request is accepted on a rising edge where RESET=0 and BUSY=0; read
  // data appears one cycle later qualified by R_VALID, with ADDR_ERR in the same cycle.
  typedef enum logic {CLEAR = 1'b0, READY = 1'b1} state_t;

  localparam logic [ADDR_W:0]   DEPTH_EXT = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  state_t              state, state_nxt;
  logic [ADDR_W-1:0]   cnt;
  logic [DATA_W-1:0]   mem [DEPTH];
  logic                in_range;
  logic                mem_we;
  logic [ADDR_W-1:0]   mem_waddr;
  logic [DATA_W-1:0]   mem_wdata;
  logic [ADDR_W-1:0]   rd_idx;
  logic [DATA_W-1:0]   rd_word;
  logic                req_ready;

  // One extra bit keeps DEPTH == 2**ADDR_W from ever flagging.
  assign in_range  = {1'b0, ADDR} < DEPTH_EXT;
  assign req_ready = (state == READY) && !RESET;
  assign BUSY      = (state == CLEAR);
  assign STATE_DBG = state;

  always_comb begin
    state_nxt = state;
    mem_we    = 1'b0;
    mem_waddr = cnt;
    mem_wdata = CLR_VAL;
    case (state)
      CLEAR: begin
        mem_we = 1'b1;
        if (cnt == LAST_ADDR) state_nxt = READY;
      end
      READY: begin
        mem_we    = W_ENABLE && in_range;
        mem_waddr = ADDR;
        mem_wdata = D_IN;
      end
      default: state_nxt = CLEAR;
    endcase
    if (RESET) begin
      state_nxt = CLEAR;
      mem_we    = 1'b0;
    end
  end

  always_comb begin
    rd_idx  = in_range ? ADDR : '0;
    rd_word = '0;
    if (in_range) begin
      if ((RDW_MODE != 0) && W_ENABLE) rd_word = D_IN;
      else                             rd_word = mem[rd_idx];
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state <= CLEAR;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      if (state == CLEAR) cnt <= cnt + 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      D_OUT    <= '0;
      R_VALID  <= 1'b0;
      ADDR_ERR <= 1'b0;
    end else begin
      R_VALID  <= req_ready && R_ENABLE;
      ADDR_ERR <= req_ready && (R_ENABLE || W_ENABLE) && !in_range;
      if (req_ready && R_ENABLE) D_OUT <= rd_word;
    end
  end

endmodule

// File: tb/tb_param_sync_ram_clr.sv
// Bench for param_sync_ram_clr: a default instance and a DEPTH=48 write-first instance share
// stimulus and are each checked every cycle against an array-based reference model.
module tb_param_sync_ram_clr;

  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic [7:0] D_IN = '0;
  logic [5:0] ADDR = '0;
  logic       R_ENABLE = 1'b0;
  logic       W_ENABLE = 1'b0;

  logic [7:0] d_out0, d_out1;
  logic       r_valid0, r_valid1, busy0, busy1, addr_err0, addr_err1, state0, state1;

  int checks = 0;
  int failures = 0;

  // Reference model: instance 0 = DEPTH 64 read-first, instance 1 = DEPTH 48 write-first.
  int         m_depth [2] = '{64, 48};
  int         m_mode  [2] = '{0, 1};
  logic [7:0] m_mem   [2][64];
  int         m_busy  [2];
  logic [7:0] m_dout  [2];
  logic       m_rv    [2];
  logic       m_err   [2];
  logic [7:0] exp_q[$];

  always #10 CLK = ~CLK;

  param_sync_ram_clr dut0 (
    .CLK(CLK), .RESET(RESET), .D_IN(D_IN), .ADDR(ADDR), .R_ENABLE(R_ENABLE),
    .W_ENABLE(W_ENABLE), .D_OUT(d_out0), .R_VALID(r_valid0), .BUSY(busy0),
    .ADDR_ERR(addr_err0), .STATE_DBG(state0)
  );

  param_sync_ram_clr #(.DEPTH(48), .RDW_MODE(1)) dut1 (
    .CLK(CLK), .RESET(RESET), .D_IN(D_IN), .ADDR(ADDR), .R_ENABLE(R_ENABLE),
    .W_ENABLE(W_ENABLE), .D_OUT(d_out1), .R_VALID(r_valid1), .BUSY(busy1),
    .ADDR_ERR(addr_err1), .STATE_DBG(state1)
  );

  task automatic chk(input string tag, input int inst, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s[%0d] observed=%0h expected=%0h", tag, inst, obs, exp);
    end
  endtask

  task automatic model_edge(input bit rst, input bit r, input bit w,
                            input logic [5:0] a, input logic [7:0] d);
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        for (int k = 0; k < 64; k++) m_mem[i][k] = 8'h00;
        m_busy[i] = m_depth[i];
        m_dout[i] = 8'h00;
        m_rv[i]   = 1'b0;
        m_err[i]  = 1'b0;
      end else if (m_busy[i] > 0) begin
        m_busy[i]--;
        m_rv[i]  = 1'b0;
        m_err[i] = 1'b0;
      end else begin
        m_rv[i]  = r;
        m_err[i] = (r || w) && (int'(a) >= m_depth[i]);
        if (r) begin
          if (int'(a) >= m_depth[i])  m_dout[i] = 8'h00;
          else if (m_mode[i] == 1 && w) m_dout[i] = d;
          else                          m_dout[i] = m_mem[i][a];
        end
        if (w && int'(a) < m_depth[i]) m_mem[i][a] = d;
      end
      exp_q.push_back(m_dout[i]);
    end
  endtask

  task automatic step(input bit rst, input bit r, input bit w,
                      input logic [5:0] a, input logic [7:0] d);
    logic [7:0] e;
    RESET = rst; R_ENABLE = r; W_ENABLE = w; ADDR = a; D_IN = d;
    @(posedge CLK);
    model_edge(rst, r, w, a, d);
    @(negedge CLK);
    e = exp_q.pop_front();
    chk("d_out", 0, 32'(d_out0), 32'(e));
    chk("r_valid", 0, 32'(r_valid0), 32'(m_rv[0]));
    chk("addr_err", 0, 32'(addr_err0), 32'(m_err[0]));
    chk("busy", 0, 32'(busy0), 32'(m_busy[0] > 0));
    e = exp_q.pop_front();
    chk("d_out", 1, 32'(d_out1), 32'(e));
    chk("r_valid", 1, 32'(r_valid1), 32'(m_rv[1]));
    chk("addr_err", 1, 32'(addr_err1), 32'(m_err[1]));
    chk("busy", 1, 32'(busy1), 32'(m_busy[1] > 0));
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(0, 0, 0, 6'd0, 8'h00);
  endtask

  task automatic rd(input logic [5:0] a);
    step(0, 1, 0, a, 8'h00);
  endtask

  task automatic wr(input logic [5:0] a, input logic [7:0] d);
    step(0, 0, 1, a, d);
  endtask

  initial begin
    int busy_len;
    @(negedge CLK);

    // Reset and clear: count BUSY cycles of the default instance directly.
    step(1, 0, 0, 6'd0, 8'h00);
    step(1, 0, 0, 6'd0, 8'h00);
    busy_len = 0;
    for (int k = 0; k < 80 && busy0 === 1'b1; k++) begin
      idle(1);
      busy_len++;
    end
    chk("busy_len", 0, 32'(busy_len), 32'd64);
    rd(6'd0); rd(6'd31); rd(6'd63);
    chk("clr_word63", 0, 32'(d_out0), 32'h00);

    // Write then back-to-back reads.
    wr(6'd5, 8'h01); wr(6'd63, 8'hA5);
    rd(6'd5);
    chk("rd5", 0, 32'(d_out0), 32'h01);
    rd(6'd63);
    chk("rd63", 0, 32'(d_out0), 32'hA5);

    // Read-during-write on one address.
    wr(6'd0, 8'h01);
    step(0, 1, 1, 6'd0, 8'h02);
    chk("rdw_old", 0, 32'(d_out0), 32'h01);
    chk("rdw_new", 1, 32'(d_out1), 32'h02);
    rd(6'd0);

    // Requests during clear are ignored.
    step(1, 0, 0, 6'd0, 8'h00);
    wr(6'd3, 8'hFF);
    for (int k = 0; k < 10; k++)
      step(0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           6'($urandom_range(0, 63)), 8'($urandom_range(0, 255)));
    idle(60);
    rd(6'd3);

    // Out of range on the DEPTH=48 instance; addr 2 must not alias addr 50.
    wr(6'd2, 8'h5A);
    wr(6'd50, 8'h77);
    chk("oor_err_w", 1, 32'(addr_err1), 32'd1);
    rd(6'd50);
    chk("oor_err_r", 1, 32'(addr_err1), 32'd1);
    rd(6'd2);
    chk("no_wrap", 1, 32'(d_out1), 32'h5A);
    rd(6'd47); rd(6'd48);

    // Reset on the same edge as an access, then again mid-clear.
    step(1, 1, 1, 6'd9, 8'h3C);
    idle(20);
    step(1, 0, 0, 6'd0, 8'h00);
    idle(64);
    rd(6'd9);
    chk("rd9_cleared", 0, 32'(d_out0), 32'h00);

    // Randomised traffic with occasional resets.
    for (int k = 0; k < 600; k++)
      step(($urandom_range(0, 149) == 0), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), 6'($urandom_range(0, 63)),
           8'($urandom_range(0, 255)));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
